// File: rtl/reg_access_sequencer.sv
// reg_access_sequencer: decodes UART command frames into register writes/reads and streams the response words.
// Ports: clk/i_reset (async active-low); i_frame/i_frame_dv command frame in; o_w_* write strobe/address/value;
// o_r_en/o_r_addr read request with i_r_value/i_r_valid read return; i_tx_afull/o_tx_data/o_tx_dv response words;
// o_busy while a frame is in flight; o_err_count/o_drop_count saturating error and dropped-frame counters.
module reg_access_sequencer #(
    parameter int                    WORD_WIDTH  = 8,
    parameter int                    VALUE_WORDS = 4,
    parameter int                    REG_DEPTH   = 16,
    parameter logic [WORD_WIDTH-1:0] CMD_WRITE   = 8'h57,
    parameter logic [WORD_WIDTH-1:0] CMD_READ    = 8'h52,
    parameter logic [WORD_WIDTH-1:0] ACK_WORD    = 8'h06,
    parameter logic [WORD_WIDTH-1:0] ERR_WORD    = 8'hEE,
    parameter int                    TIMEOUT     = 15
) (
    input  logic                                clk,
    input  logic                                i_reset,
    input  logic [WORD_WIDTH*(VALUE_WORDS+2)-1:0] i_frame,
    input  logic                                i_frame_dv,
    output logic                                o_busy,
    output logic                                o_w_en,
    output logic [WORD_WIDTH-1:0]               o_w_addr,
    output logic [WORD_WIDTH*VALUE_WORDS-1:0]   o_w_value,
    output logic                                o_r_en,
    output logic [WORD_WIDTH-1:0]               o_r_addr,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0]   i_r_value,
    input  logic                                i_r_valid,
    input  logic                                i_tx_afull,
    output logic [WORD_WIDTH-1:0]               o_tx_data,
    output logic                                o_tx_dv,
    output logic [WORD_WIDTH-1:0]               o_err_count,
    output logic [WORD_WIDTH-1:0]               o_drop_count
);
    localparam int VW = WORD_WIDTH * VALUE_WORDS;
    localparam int FW = WORD_WIDTH * (VALUE_WORDS + 2);
    localparam int CW = $clog2(VALUE_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, SEND} state_t;
    state_t state, next_state;
    logic [VW-1:0] buf_q, nbuf;
    logic [CW-1:0] cnt, ncnt;
    logic [TW-1:0] wait_cnt;
    logic [WORD_WIDTH-1:0] cmd, addr;
    logic [VW-1:0] value;
    logic addr_ok, is_write, is_read, bad, timeout, err_load, ack_load, data_load, sending;
    assign cmd       = i_frame[FW-1 -: WORD_WIDTH];
    assign addr      = i_frame[VW+WORD_WIDTH-1 -: WORD_WIDTH];
    assign value     = i_frame[VW-1:0];
    assign addr_ok   = int'(addr) < REG_DEPTH;
    assign is_write  = cmd == CMD_WRITE && addr_ok;
    assign is_read   = cmd == CMD_READ && addr_ok;
    assign bad       = state == IDLE && i_frame_dv && !is_write && !is_read;
    assign timeout   = state == READ_WAIT && !i_r_valid && wait_cnt == TW'(TIMEOUT - 1);
    assign err_load  = bad || timeout;
    assign ack_load  = state == WRITE;
    assign data_load = state == READ_WAIT && i_r_valid;
    // Response words sit MSB-first in nbuf; the first word is emitted on the edge that enters SEND,
    // so an ACK appears the cycle right after the write strobe.
    assign nbuf      = data_load ? i_r_value
                     : err_load  ? {ERR_WORD, {(VW-WORD_WIDTH){1'b0}}}
                     : ack_load  ? {ACK_WORD, {(VW-WORD_WIDTH){1'b0}}}
                     : buf_q;
    assign ncnt      = data_load ? CW'(VALUE_WORDS) : (err_load || ack_load) ? CW'(1) : cnt;
    assign sending   = err_load || ack_load || data_load || (state == SEND && cnt != '0);
    assign next_state = state == IDLE      ? (i_frame_dv ? (is_write ? WRITE : is_read ? READ_REQ : SEND) : IDLE)
                      : state == WRITE     ? SEND
                      : state == READ_REQ  ? READ_WAIT
                      : state == READ_WAIT ? ((i_r_valid || timeout) ? SEND : READ_WAIT)
                      : (cnt == '0 ? IDLE : SEND);
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            buf_q        <= '0;
            cnt          <= '0;
            wait_cnt     <= '0;
            o_busy       <= 1'b0;
            o_w_en       <= 1'b0;
            o_w_addr     <= '0;
            o_w_value    <= '0;
            o_r_en       <= 1'b0;
            o_r_addr     <= '0;
            o_tx_data    <= '0;
            o_tx_dv      <= 1'b0;
            o_err_count  <= '0;
            o_drop_count <= '0;
        end else begin
            state   <= next_state;
            o_busy  <= next_state != IDLE;
            o_w_en  <= state == IDLE && i_frame_dv && is_write;
            o_r_en  <= state == IDLE && i_frame_dv && is_read;
            o_tx_dv <= sending && !i_tx_afull;
            if (state == IDLE && i_frame_dv && is_write) begin
                o_w_addr  <= addr;
                o_w_value <= value;
            end
            if (state == IDLE && i_frame_dv && is_read)
                o_r_addr <= addr;
            wait_cnt <= state == READ_WAIT ? wait_cnt + 1'b1 : '0;
            // A stalled cycle reloads the buffer unshifted so no word is lost or repeated.
            if (sending) begin
                o_tx_data <= i_tx_afull ? o_tx_data : nbuf[VW-1 -: WORD_WIDTH];
                buf_q     <= i_tx_afull ? nbuf : nbuf << WORD_WIDTH;
                cnt       <= i_tx_afull ? ncnt : ncnt - 1'b1;
            end
            if (err_load && o_err_count != '1)
                o_err_count <= o_err_count + 1'b1;
            if (state != IDLE && i_frame_dv && o_drop_count != '1)
                o_drop_count <= o_drop_count + 1'b1;
        end
    end
endmodule
